// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon player panel.
//   panel_state_t : encoder FSM states
//   btn_idx_t     : 2-bit button index
//   lowest_idx()  : lowest set bit of a button vector (priority encoder)
//   onehot()      : button index to one-hot LED vector
package simon_pkg;
  localparam int NUM_BUTTONS    = 4;
  localparam int DEBOUNCE_CNT_W = 4;
  localparam int BLINK_CNT_W    = 6;

  typedef enum logic [1:0] {IDLE, STROBE, HELD, LOCKED} panel_state_t;
  typedef logic [1:0] btn_idx_t;

  function automatic btn_idx_t lowest_idx(input logic [NUM_BUTTONS-1:0] v);
    btn_idx_t idx;
    idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--)
      if (v[i]) idx = btn_idx_t'(i);
    return idx;
  endfunction

  function automatic logic [NUM_BUTTONS-1:0] onehot(input btn_idx_t n);
    logic [NUM_BUTTONS-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/simon_panel_if.sv
// simon_panel_if: board/game-core signals of the player panel.
//   master : drives btn, simon_turn, simon_num, simon_pressed, game_over
//   slave  : the panel; drives player_num, player_pressed, led
//            (and press_count when SIMON_PANEL_COUNT_EN is defined)
interface simon_panel_if;
  import simon_pkg::*;
  logic [NUM_BUTTONS-1:0] btn;
  logic                   simon_turn;
  btn_idx_t               simon_num;
  logic                   simon_pressed;
  logic                   game_over;
  btn_idx_t               player_num;
  logic                   player_pressed;
  logic [NUM_BUTTONS-1:0] led;
`ifdef SIMON_PANEL_COUNT_EN
  logic [7:0]             press_count;

  modport master (output btn, simon_turn, simon_num, simon_pressed, game_over,
                  input  player_num, player_pressed, led, press_count);
  modport slave  (input  btn, simon_turn, simon_num, simon_pressed, game_over,
                  output player_num, player_pressed, led, press_count);
`else
  modport master (output btn, simon_turn, simon_num, simon_pressed, game_over,
                  input  player_num, player_pressed, led);
  modport slave  (input  btn, simon_turn, simon_num, simon_pressed, game_over,
                  output player_num, player_pressed, led);
`endif
endinterface

// File: rtl/simon_panel_debouncer.sv
// button_debouncer: one raw button -> 2-flop synchronizer -> debounced level.
//   clk, reset (sync, active-low), raw (async button), level (debounced).
// The level flips only after DEBOUNCE_TICKS consecutive synced samples that
// disagree with it; any agreeing sample restarts the count.
module button_debouncer
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam logic [DEBOUNCE_CNT_W-1:0] LIMIT = DEBOUNCE_CNT_W'(DEBOUNCE_TICKS);

  logic [1:0]                sync;
  logic [DEBOUNCE_CNT_W-1:0] cnt;
  logic [DEBOUNCE_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + DEBOUNCE_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != level) begin
        if (cnt_inc == LIMIT) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/simon_panel.sv
// simon_panel: player-side end of the Simon button/LED interface.
//   clk   : 60 Hz clock, rising edge
//   reset : synchronous, active-low
//   bus   : simon_panel_if.slave (buttons and Simon status in;
//           player_num / player_pressed / led out)
// Optional: define SIMON_PANEL_COUNT_EN for the saturating press_count output.
// Four debouncers feed a small accept FSM: one strobe per press, no repeat
// until every button is released; a lock (Simon's turn / game over) always
// exits through HELD so a button held across the lock is not accepted.
module simon_panel
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int BLINK_TICKS    = 15
) (
  input logic         clk,
  input logic         reset,
  simon_panel_if.slave bus
);
  localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_TICKS - 1);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] level_q;
  logic [NUM_BUTTONS-1:0] rise;
  panel_state_t           state, state_nxt;
  btn_idx_t               num_q;
  logic [BLINK_CNT_W-1:0] blink_cnt;
  logic                   blink_phase;
  logic                   lock;
  logic                   accept;

  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db [NUM_BUTTONS-1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn),
    .level (level)
  );

  assign lock   = bus.simon_turn | bus.game_over;
  assign rise   = level & ~level_q;
  assign accept = (state == IDLE) && !lock && (rise != '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (lock) state_nxt = LOCKED;
               else if (accept) state_nxt = STROBE;
      STROBE:  state_nxt = HELD;
      HELD:    if (lock) state_nxt = LOCKED;
               else if (level == '0) state_nxt = IDLE;
      LOCKED:  if (!lock) state_nxt = HELD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      level_q     <= '0;
      num_q       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state   <= state_nxt;
      level_q <= level;
      if (accept) num_q <= lowest_idx(rise);
      // blink timer only runs during game over and restarts dark each time
      if (bus.game_over) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
        end
      end else begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end
    end
  end

  assign bus.player_num     = num_q;
  assign bus.player_pressed = (state == STROBE);

  always_comb begin
    bus.led = level_q;
    if (bus.game_over)       bus.led = blink_phase ? '1 : '0;
    else if (bus.simon_turn) bus.led = bus.simon_pressed ? onehot(bus.simon_num) : '0;
  end

`ifdef SIMON_PANEL_COUNT_EN
  logic [7:0] press_cnt;
  always_ff @(posedge clk) begin
    if (!reset)                                  press_cnt <= '0;
    else if (state == STROBE && press_cnt != '1) press_cnt <= press_cnt + 8'd1;
  end
  assign bus.press_count = press_cnt;
`endif
endmodule

// File: tb/tb_simon_panel.sv
module tb_simon_panel;
  localparam int DB = 3;
  localparam int BL = 15;
  localparam int M_IDLE = 0, M_STROBE = 1, M_HELD = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  simon_panel_if bus();

  simon_panel #(.DEBOUNCE_TICKS(DB), .BLINK_TICKS(BL)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: raw value reaches the debouncer two edges late; the debounced
  // level flips after DB consecutive disagreeing samples.
  bit [3:0] m_s1, m_s2, m_deb, m_deb_q;
  int       m_run [4];
  int       m_mode;
  bit [1:0] m_pnum;
  bit       m_phase;
  int       m_bcnt;
  int       m_cnt;
  bit       m_valid = 0;

  task automatic model_step();
    bit [3:0] rise;
    bit lock;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_q = 0;
      foreach (m_run[i]) m_run[i] = 0;
      m_mode = M_IDLE; m_pnum = 0; m_phase = 0; m_bcnt = 0; m_cnt = 0;
      m_valid = 1;
      return;
    end
    lock = bus.simon_turn | bus.game_over;
    rise = m_deb & ~m_deb_q;
    if (m_mode == M_STROBE && m_cnt < 255) m_cnt++;
    case (m_mode)
      M_IDLE:
        if (lock) m_mode = M_LOCK;
        else if (rise != 0) begin
          for (int i = 3; i >= 0; i--) if (rise[i]) m_pnum = 2'(i);
          m_mode = M_STROBE;
        end
      M_STROBE: m_mode = M_HELD;
      M_HELD:
        if (lock) m_mode = M_LOCK;
        else if (m_deb == 0) m_mode = M_IDLE;
      default:
        if (!lock) m_mode = M_HELD;
    endcase
    m_deb_q = m_deb;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = bus.btn;
    if (bus.game_over) begin
      m_bcnt++;
      if (m_bcnt == BL) begin
        m_bcnt = 0;
        m_phase = ~m_phase;
      end
    end else begin
      m_bcnt = 0;
      m_phase = 0;
    end
  endtask

  function automatic bit [3:0] exp_led();
    bit [3:0] one;
    one = 4'b0001;
    if (bus.game_over) return m_phase ? 4'hF : 4'h0;
    if (bus.simon_turn) return bus.simon_pressed ? (one << bus.simon_num) : 4'h0;
    return m_deb_q;
  endfunction

  // per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        check("player_pressed", 8'(bus.player_pressed), 8'(m_mode == M_STROBE));
        check("player_num", 8'(bus.player_num), 8'(m_pnum));
        check("led", 8'(bus.led), 8'(exp_led()));
`ifdef SIMON_PANEL_COUNT_EN
        check("press_count", bus.press_count, 8'(m_cnt));
`endif
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic idle_cycles(input int n, output int strobes);
    strobes = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.player_pressed) strobes++;
    end
  endtask

  initial begin
    int s, at, bad, got;
    bit seen;
    bus.btn = 0; bus.simon_turn = 0; bus.simon_num = 0;
    bus.simon_pressed = 0; bus.game_over = 0;
    repeat (3) @(negedge clk);
    check("reset_pressed", 8'(bus.player_pressed), 8'd0);
    check("reset_led", 8'(bus.led), 8'd0);
    check("reset_num", 8'(bus.player_num), 8'd0);
    reset = 1'b1;
    idle_cycles(4, s);

    // 1: single press, latency and echo
    bus.btn = 4'b0100;
    at = 0; s = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.player_pressed) begin s++; at = i; end
    end
    check("t1_strobes", 8'(s), 8'd1);
    check("t1_latency", 8'(at), 8'(DB + 3));
    check("t1_num", 8'(bus.player_num), 8'd2);
    check("t1_led", 8'(bus.led), 8'h4);
    bus.btn = 0;
    idle_cycles(10, s);

    // 2: one-cycle bounces never debounce
    got = 0;
    for (int i = 0; i < 8; i++) begin
      bus.btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      idle_cycles(1, s); got += s;
    end
    bus.btn = 0;
    idle_cycles(10, s); got += s;
    check("t2_strobes", 8'(got), 8'd0);
    check("t2_led", 8'(bus.led), 8'd0);

    // 3: simultaneous rise, lowest index wins; no repeat until full release
    bus.btn = 4'b1010;
    idle_cycles(10, s);
    check("t3_strobes", 8'(s), 8'd1);
    check("t3_num", 8'(bus.player_num), 8'd1);
    bus.btn = 4'b1000;
    idle_cycles(10, s);
    check("t3_partial_release", 8'(s), 8'd0);
    bus.btn = 0;
    idle_cycles(10, s);
    bus.btn = 4'b1000;
    idle_cycles(10, s);
    check("t3_repress", 8'(s), 8'd1);
    check("t3_repress_num", 8'(bus.player_num), 8'd3);
    bus.btn = 0;
    idle_cycles(10, s);

    // 4: Simon's turn mirrors Simon, held button needs a release afterwards
    bus.simon_turn = 1; bus.simon_num = 3; bus.simon_pressed = 1; bus.btn = 4'b0001;
    idle_cycles(10, s);
    check("t4_led", 8'(bus.led), 8'h8);
    check("t4_locked", 8'(s), 8'd0);
    bus.simon_turn = 0; bus.simon_pressed = 0;
    idle_cycles(10, s);
    check("t4_held_after_lock", 8'(s), 8'd0);
    bus.btn = 0;
    idle_cycles(10, s);
    bus.btn = 4'b0001;
    idle_cycles(10, s);
    check("t4_repress", 8'(s), 8'd1);
    check("t4_repress_num", 8'(bus.player_num), 8'd0);
    bus.btn = 0;
    idle_cycles(10, s);

    // 5: game-over blink: 15 dark, 15 lit, then dark; presses ignored
    bus.game_over = 1; bus.btn = 4'b0010;
    bad = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) #1; else @(negedge clk);
      if (bus.player_pressed) got++;
      if (bus.led !== ((i >= 15 && i < 30) ? 4'hF : 4'h0)) bad++;
    end
    check("t5_blink_errors", 8'(bad), 8'd0);
    check("t5_strobes", 8'(got), 8'd0);
    bus.game_over = 0; bus.btn = 0;
    idle_cycles(12, s);

    // 6: reset in the STROBE cycle drops the strobe
    bus.btn = 4'b0001;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.player_pressed) seen = 1;
    end
    check("t6_strobe_seen", 8'(seen), 8'd1);
    reset = 1'b0; bus.btn = 0;
    @(negedge clk);
    check("t6_pressed", 8'(bus.player_pressed), 8'd0);
    check("t6_num", 8'(bus.player_num), 8'd0);
    check("t6_led", 8'(bus.led), 8'd0);
    reset = 1'b1;
    idle_cycles(4, s);

`ifdef SIMON_PANEL_COUNT_EN
    for (int n = 0; n < 300; n++) begin
      bus.btn = 4'b0001;
      idle_cycles(8, s);
      bus.btn = 0;
      idle_cycles(8, s);
    end
    check("count_saturates", bus.press_count, 8'd255);
`endif

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.btn = 0;
          1: bus.btn = 4'(1 << $urandom_range(0, 3));
          2: bus.btn = 4'($urandom);
          default: bus.btn = 0;
        endcase
      end
      if ($urandom_range(0, 59) == 0) bus.simon_turn = ~bus.simon_turn;
      if ($urandom_range(0, 89) == 0) bus.game_over = ~bus.game_over;
      bus.simon_num = 2'($urandom);
      bus.simon_pressed = 1'($urandom);
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
